mem_bus_arbiter: RTL and testbench

//  Shares the single memory request/response port between two masters: port 0 (core-side

---
 rtl/mem_bus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master to one-memory-port arbiter with round-robin or fixed-priority grant.
// Latency: request pulse -> memory pulse after 2 edges when idle; memory response -> master response after 1 edge.
// Backpressure: none; one latched request per master, and pulses while pending or owning are dropped.
//
// Ports:
//   i_clk, i_rstn                   clock, asynchronous active-low reset
//   i_pN_request_enable/mode/addr/wdata/wstrb   master N request pulse and fields (N=0,1)
//   o_pN_response_enable, o_pN_data             master N completion pulse and read data
//   o_mem_request_enable/mode/addr/wdata/wstrb  request pulse and fields to memory
//   i_mem_response_enable, i_mem_data           completion pulse and read data from memory
//   o_busy                                      high while a transaction is in flight
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_p0_request_enable,
  input  logic                i_p0_mode,
  input  logic [ADDR_W-1:0]   i_p0_addr,
  input  logic [DATA_W-1:0]   i_p0_wdata,
  input  logic [DATA_W/8-1:0] i_p0_wstrb,
  output logic                o_p0_response_enable,
  output logic [DATA_W-1:0]   o_p0_data,
  input  logic                i_p1_request_enable,
  input  logic                i_p1_mode,
  input  logic [ADDR_W-1:0]   i_p1_addr,
  input  logic [DATA_W-1:0]   i_p1_wdata,
  input  logic [DATA_W/8-1:0] i_p1_wstrb,
  output logic                o_p1_response_enable,
  output logic [DATA_W-1:0]   o_p1_data,
  output logic                o_mem_request_enable,
  output logic                o_mem_mode,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_wstrb,
  input  logic                i_mem_response_enable,
  input  logic [DATA_W-1:0]   i_mem_data,
  output logic                o_busy
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]        r_pend;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_addr  [2];
  logic [DATA_W-1:0] r_wdata [2];
  logic [STRB_W-1:0] r_wstrb [2];
  logic              r_owner;
  logic              r_last_grant;

  logic [1:0]        w_req;
  logic [1:0]        w_mode_in;
  logic [ADDR_W-1:0] w_addr_in  [2];
  logic [DATA_W-1:0] w_wdata_in [2];
  logic [STRB_W-1:0] w_wstrb_in [2];
  logic [1:0]        w_owned;
  logic [1:0]        w_accept;
  logic [1:0]        w_is_win;
  logic              w_winner;
  logic              w_grant;
  logic              w_deliver;

  assign w_req         = {i_p1_request_enable, i_p0_request_enable};
  assign w_mode_in     = {i_p1_mode, i_p0_mode};
  assign w_addr_in[0]  = i_p0_addr;
  assign w_addr_in[1]  = i_p1_addr;
  assign w_wdata_in[0] = i_p0_wdata;
  assign w_wdata_in[1] = i_p1_wdata;
  assign w_wstrb_in[0] = i_p0_wstrb;
  assign w_wstrb_in[1] = i_p1_wstrb;

  assign o_busy = (r_state == S_WAIT);

  // Ownership ends on the edge the response is delivered, so the owner may
  // queue its next request on that same edge.
  assign w_owned[0] = o_busy & ~r_owner & ~i_mem_response_enable;
  assign w_owned[1] = o_busy &  r_owner & ~i_mem_response_enable;
  assign w_accept   = w_req & ~r_pend & ~w_owned;

  // With both pending, fixed priority picks port 0; round-robin picks the
  // port that did not win last. With one pending, that one wins.
  always_comb begin
    w_winner = r_pend[1];
    if (&r_pend) begin
      w_winner = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
    end
  end

  assign w_is_win = {w_winner, ~w_winner};

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_deliver   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          w_grant     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mem_response_enable) begin
          w_deliver   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Per-port request latches. Accept and grant of the same port are mutually
  // exclusive because accept requires the port not to be pending.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pend <= '0;
      r_mode <= '0;
      for (int n = 0; n < 2; n++) begin
        r_addr[n]  <= '0;
        r_wdata[n] <= '0;
        r_wstrb[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_accept[n]) begin
          r_pend[n]  <= 1'b1;
          r_mode[n]  <= w_mode_in[n];
          r_addr[n]  <= w_addr_in[n];
          r_wdata[n] <= w_wdata_in[n];
          r_wstrb[n] <= w_wstrb_in[n];
        end else if (w_grant && w_is_win[n]) begin
          r_pend[n] <= 1'b0;
        end
      end
    end
  end

  // Memory side: fields hold the last granted request between transactions.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_mem_request_enable <= 1'b0;
      o_mem_mode           <= 1'b0;
      o_mem_addr           <= '0;
      o_mem_wdata          <= '0;
      o_mem_wstrb          <= '0;
      r_owner              <= 1'b0;
      r_last_grant         <= 1'b1;
    end else begin
      o_mem_request_enable <= w_grant;
      if (w_grant) begin
        o_mem_mode   <= r_mode[w_winner];
        o_mem_addr   <= r_addr[w_winner];
        o_mem_wdata  <= r_wdata[w_winner];
        o_mem_wstrb  <= r_wstrb[w_winner];
        r_owner      <= w_winner;
        r_last_grant <= w_winner;
      end
    end
  end

  // Master side: only the owner sees the pulse; the other port's data holds.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_p0_response_enable <= 1'b0;
      o_p1_response_enable <= 1'b0;
      o_p0_data            <= '0;
      o_p1_data            <= '0;
    end else begin
      o_p0_response_enable <= w_deliver & ~r_owner;
      o_p1_response_enable <= w_deliver &  r_owner;
      if (w_deliver && !r_owner) begin
        o_p0_data <= i_mem_data;
      end
      if (w_deliver && r_owner) begin
        o_p1_data <= i_mem_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        p0_req = 1'b0, p0_mode = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic [3:0]  p0_wstrb = '0;
  logic        p1_req = 1'b0, p1_mode = 1'b0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic [3:0]  p1_wstrb = '0;
  logic        mem_resp = 1'b0;
  logic [31:0] mem_data = '0;

  logic        a_p0_resp, a_p1_resp, a_mem_req, a_mem_mode, a_busy;
  logic [31:0] a_p0_data, a_p1_data, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wstrb;
  logic        b_p0_resp, b_p1_resp, b_mem_req, b_mem_mode, b_busy;
  logic [31:0] b_p0_data, b_p1_data, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_wstrb;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut_rr (
    .i_clk(clk), .i_rstn(rstn),
    .i_p0_request_enable(p0_req), .i_p0_mode(p0_mode), .i_p0_addr(p0_addr),
    .i_p0_wdata(p0_wdata), .i_p0_wstrb(p0_wstrb),
    .o_p0_response_enable(a_p0_resp), .o_p0_data(a_p0_data),
    .i_p1_request_enable(p1_req), .i_p1_mode(p1_mode), .i_p1_addr(p1_addr),
    .i_p1_wdata(p1_wdata), .i_p1_wstrb(p1_wstrb),
    .o_p1_response_enable(a_p1_resp), .o_p1_data(a_p1_data),
    .o_mem_request_enable(a_mem_req), .o_mem_mode(a_mem_mode), .o_mem_addr(a_mem_addr),
    .o_mem_wdata(a_mem_wdata), .o_mem_wstrb(a_mem_wstrb),
    .i_mem_response_enable(mem_resp), .i_mem_data(mem_data), .o_busy(a_busy)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
    .i_clk(clk), .i_rstn(rstn),
    .i_p0_request_enable(p0_req), .i_p0_mode(p0_mode), .i_p0_addr(p0_addr),
    .i_p0_wdata(p0_wdata), .i_p0_wstrb(p0_wstrb),
    .o_p0_response_enable(b_p0_resp), .o_p0_data(b_p0_data),
    .i_p1_request_enable(p1_req), .i_p1_mode(p1_mode), .i_p1_addr(p1_addr),
    .i_p1_wdata(p1_wdata), .i_p1_wstrb(p1_wstrb),
    .o_p1_response_enable(b_p1_resp), .o_p1_data(b_p1_data),
    .o_mem_request_enable(b_mem_req), .o_mem_mode(b_mem_mode), .o_mem_addr(b_mem_addr),
    .o_mem_wdata(b_mem_wdata), .o_mem_wstrb(b_mem_wstrb),
    .i_mem_response_enable(mem_resp), .i_mem_data(mem_data), .o_busy(b_busy)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    n_chk++; if (a_busy !== 1'b0) $display("FAIL rst_busy got %0h want 0", a_busy); else n_pass++;
    n_chk++; if ({a_mem_req, a_p0_resp, a_p1_resp, a_mem_mode} !== 4'b0) $display("FAIL rst_pulses got %b want 0000", {a_mem_req, a_p0_resp, a_p1_resp, a_mem_mode}); else n_pass++;
    n_chk++; if ({a_p0_data, a_p1_data, a_mem_addr, a_mem_wdata} !== 128'h0) $display("FAIL rst_data got %h want 0", {a_p0_data, a_p1_data, a_mem_addr, a_mem_wdata}); else n_pass++;
    rstn = 1'b1;
    // Start a transaction and abandon it with reset while in WAIT.
    p0_req = 1'b1; p0_mode = 1'b0; p0_addr = 32'h40;
    cyc(); p0_req = 1'b0;
    cyc();
    n_chk++; if (a_busy !== 1'b1) $display("FAIL rst_pre_busy got %0h want 1", a_busy); else n_pass++;
    cyc();
    rstn = 1'b0;
    #2;
    n_chk++; if ({a_busy, a_mem_req} !== 2'b00) $display("FAIL rst_async_busy got %b want 00", {a_busy, a_mem_req}); else n_pass++;
    n_chk++; if (a_mem_addr !== 32'h0) $display("FAIL rst_async_addr got %h want 0", a_mem_addr); else n_pass++;
    #2;
    rstn = 1'b1;
    cyc();
    mem_resp = 1'b1; mem_data = 32'h1234;
    cyc(); mem_resp = 1'b0;
    n_chk++; if ({a_p0_resp, a_p1_resp} !== 2'b00) $display("FAIL rst_late_resp got %b want 00", {a_p0_resp, a_p1_resp}); else n_pass++;
    n_chk++; if (a_p0_data !== 32'h0) $display("FAIL rst_late_data got %h want 0", a_p0_data); else n_pass++;
    n_chk++; if ({a_busy, a_mem_req} !== 2'b00) $display("FAIL rst_late_idle got %b want 00", {a_busy, a_mem_req}); else n_pass++;
  endtask

  task automatic test_single_read();
    p0_req = 1'b1; p0_mode = 1'b0; p0_addr = 32'h8000_0010;
    cyc(); p0_req = 1'b0;
    n_chk++; if (a_mem_req !== 1'b0) $display("FAIL rd_early_req got %0h want 0", a_mem_req); else n_pass++;
    cyc();
    n_chk++; if (a_mem_req !== 1'b1) $display("FAIL rd_req got %0h want 1", a_mem_req); else n_pass++;
    n_chk++; if (a_mem_addr !== 32'h8000_0010) $display("FAIL rd_addr got %h want 80000010", a_mem_addr); else n_pass++;
    n_chk++; if ({a_mem_mode, a_busy} !== 2'b01) $display("FAIL rd_mode_busy got %b want 01", {a_mem_mode, a_busy}); else n_pass++;
    cyc();
    n_chk++; if (a_mem_req !== 1'b0) $display("FAIL rd_one_pulse got %0h want 0", a_mem_req); else n_pass++;
    mem_resp = 1'b1; mem_data = 32'hDEAD_BEEF;
    cyc(); mem_resp = 1'b0;
    n_chk++; if ({a_p0_resp, a_p1_resp} !== 2'b10) $display("FAIL rd_resp got %b want 10", {a_p0_resp, a_p1_resp}); else n_pass++;
    n_chk++; if (a_p0_data !== 32'hDEAD_BEEF) $display("FAIL rd_data got %h want deadbeef", a_p0_data); else n_pass++;
    n_chk++; if (a_busy !== 1'b0) $display("FAIL rd_busy_done got %0h want 0", a_busy); else n_pass++;
    cyc();
    n_chk++; if (a_p0_resp !== 1'b0) $display("FAIL rd_resp_one_cycle got %0h want 0", a_p0_resp); else n_pass++;
  endtask

  // Port 0 won last, so round-robin now favours port 1 while fixed priority keeps port 0.
  task automatic test_fixed_prio();
    p0_req = 1'b1; p0_mode = 1'b0; p0_addr = 32'h100;
    p1_req = 1'b1; p1_mode = 1'b0; p1_addr = 32'h200;
    cyc(); p0_req = 1'b0; p1_req = 1'b0;
    cyc();
    n_chk++; if (a_mem_addr !== 32'h200) $display("FAIL rr_first_addr got %h want 200", a_mem_addr); else n_pass++;
    n_chk++; if (b_mem_addr !== 32'h100) $display("FAIL fp_first_addr got %h want 100", b_mem_addr); else n_pass++;
    mem_resp = 1'b1; mem_data = 32'h11;
    cyc(); mem_resp = 1'b0;
    n_chk++; if ({a_p0_resp, a_p1_resp} !== 2'b01) $display("FAIL rr_first_route got %b want 01", {a_p0_resp, a_p1_resp}); else n_pass++;
    n_chk++; if (a_p1_data !== 32'h11) $display("FAIL rr_first_data got %h want 11", a_p1_data); else n_pass++;
    n_chk++; if ({b_p0_resp, b_p1_resp} !== 2'b10) $display("FAIL fp_first_route got %b want 10", {b_p0_resp, b_p1_resp}); else n_pass++;
    n_chk++; if ({a_mem_req, a_busy} !== 2'b00) $display("FAIL gap_idle got %b want 00", {a_mem_req, a_busy}); else n_pass++;
    cyc();
    n_chk++; if (a_mem_req !== 1'b1) $display("FAIL gap_next_req got %0h want 1", a_mem_req); else n_pass++;
    n_chk++; if (a_mem_addr !== 32'h100) $display("FAIL rr_second_addr got %h want 100", a_mem_addr); else n_pass++;
    n_chk++; if (b_mem_addr !== 32'h200) $display("FAIL fp_second_addr got %h want 200", b_mem_addr); else n_pass++;
    mem_resp = 1'b1; mem_data = 32'h22;
    cyc(); mem_resp = 1'b0;
    n_chk++; if ({a_p0_resp, a_p0_data} !== {1'b1, 32'h22}) $display("FAIL rr_second_route got %0h/%h want 1/22", a_p0_resp, a_p0_data); else n_pass++;
    n_chk++; if ({b_p1_resp, b_p1_data} !== {1'b1, 32'h22}) $display("FAIL fp_second_route got %0h/%h want 1/22", b_p1_resp, b_p1_data); else n_pass++;
  endtask

  task automatic test_round_robin();
    rstn = 1'b0; cyc(); rstn = 1'b1; cyc();
    for (int i = 0; i < 4; i++) begin
      p0_req = 1'b1; p0_mode = 1'b0; p0_addr = 32'h1000 + 32'(i) * 32'h10;
      p1_req = 1'b1; p1_mode = 1'b0; p1_addr = 32'h2000 + 32'(i) * 32'h10;
      cyc(); p0_req = 1'b0; p1_req = 1'b0;
      cyc();
      n_chk++; if (a_mem_addr !== 32'h1000 + 32'(i) * 32'h10) $display("FAIL rr_round%0d_p0_addr got %h want %h", i, a_mem_addr, 32'h1000 + 32'(i) * 32'h10); else n_pass++;
      n_chk++; if (b_mem_addr !== 32'h1000 + 32'(i) * 32'h10) $display("FAIL fp_round%0d_p0_addr got %h want %h", i, b_mem_addr, 32'h1000 + 32'(i) * 32'h10); else n_pass++;
      mem_resp = 1'b1; mem_data = 32'hC0DE_0000 + 32'(i);
      cyc(); mem_resp = 1'b0;
      n_chk++; if ({a_p0_resp, a_p1_resp, a_p0_data} !== {2'b10, 32'hC0DE_0000 + 32'(i)}) $display("FAIL rr_round%0d_p0_resp got %b/%h want 10/%h", i, {a_p0_resp, a_p1_resp}, a_p0_data, 32'hC0DE_0000 + 32'(i)); else n_pass++;
      cyc();
      n_chk++; if ({a_mem_req, a_mem_addr} !== {1'b1, 32'h2000 + 32'(i) * 32'h10}) $display("FAIL rr_round%0d_p1_req got %0h/%h want 1/%h", i, a_mem_req, a_mem_addr, 32'h2000 + 32'(i) * 32'h10); else n_pass++;
      mem_resp = 1'b1; mem_data = 32'hBEEF_0000 + 32'(i);
      cyc(); mem_resp = 1'b0;
      n_chk++; if ({a_p0_resp, a_p1_resp, a_p1_data} !== {2'b01, 32'hBEEF_0000 + 32'(i)}) $display("FAIL rr_round%0d_p1_resp got %b/%h want 01/%h", i, {a_p0_resp, a_p1_resp}, a_p1_data, 32'hBEEF_0000 + 32'(i)); else n_pass++;
      n_chk++; if ({b_p1_resp, b_p1_data} !== {1'b1, 32'hBEEF_0000 + 32'(i)}) $display("FAIL fp_round%0d_p1_resp got %0h/%h want 1/%h", i, b_p1_resp, b_p1_data, 32'hBEEF_0000 + 32'(i)); else n_pass++;
    end
  endtask

  task automatic test_write();
    int cnt;
    p1_req = 1'b1; p1_mode = 1'b1; p1_addr = 32'h10; p1_wdata = 32'hA5A5_A5A5; p1_wstrb = 4'b0011;
    cyc(); p1_req = 1'b0;
    cyc();
    n_chk++; if ({a_mem_req, a_mem_mode} !== 2'b11) $display("FAIL wr_req_mode got %b want 11", {a_mem_req, a_mem_mode}); else n_pass++;
    n_chk++; if ({a_mem_addr, a_mem_wdata, a_mem_wstrb} !== {32'h10, 32'hA5A5_A5A5, 4'b0011}) $display("FAIL wr_fields got %h/%h/%b want 10/a5a5a5a5/0011", a_mem_addr, a_mem_wdata, a_mem_wstrb); else n_pass++;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (a_mem_req === 1'b1) cnt++;
    end
    n_chk++; if (cnt !== 0) $display("FAIL wr_extra_pulses got %0d want 0", cnt); else n_pass++;
    mem_resp = 1'b1; mem_data = 32'hFFFF_0000;
    cyc(); mem_resp = 1'b0;
    n_chk++; if ({a_p0_resp, a_p1_resp} !== 2'b01) $display("FAIL wr_resp got %b want 01", {a_p0_resp, a_p1_resp}); else n_pass++;
  endtask

  task automatic test_ignored();
    int cnt;
    p0_req = 1'b1; p0_mode = 1'b0; p0_addr = 32'h300;
    cyc(); p0_req = 1'b0;
    cyc();
    n_chk++; if ({a_mem_req, a_mem_addr} !== {1'b1, 32'h300}) $display("FAIL ign_first got %0h/%h want 1/300", a_mem_req, a_mem_addr); else n_pass++;
    p0_req = 1'b1; p0_addr = 32'h999;
    cyc(); p0_req = 1'b0;
    p1_req = 1'b1; p1_mode = 1'b0; p1_addr = 32'h400;
    cyc(); p1_req = 1'b0;
    mem_resp = 1'b1; mem_data = 32'h55;
    cyc(); mem_resp = 1'b0;
    n_chk++; if ({a_p0_resp, a_mem_req} !== 2'b10) $display("FAIL ign_resp got %b want 10", {a_p0_resp, a_mem_req}); else n_pass++;
    cyc();
    n_chk++; if ({a_mem_req, a_mem_addr} !== {1'b1, 32'h400}) $display("FAIL ign_p1_issue got %0h/%h want 1/400", a_mem_req, a_mem_addr); else n_pass++;
    mem_resp = 1'b1; mem_data = 32'h66;
    cyc(); mem_resp = 1'b0;
    n_chk++; if ({a_p1_resp, a_p1_data} !== {1'b1, 32'h66}) $display("FAIL ign_p1_resp got %0h/%h want 1/66", a_p1_resp, a_p1_data); else n_pass++;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (a_mem_req === 1'b1) cnt++;
    end
    n_chk++; if (cnt !== 0) $display("FAIL ign_no_second got %0d want 0", cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    p0_req = 1'b1; p0_mode = 1'b0; p0_addr = 32'h500;
    cyc(); p0_req = 1'b0;
    cyc();
    p0_req = 1'b1; p0_addr = 32'h600;
    mem_resp = 1'b1; mem_data = 32'h77;
    cyc(); p0_req = 1'b0; mem_resp = 1'b0;
    n_chk++; if ({a_p0_resp, a_p0_data} !== {1'b1, 32'h77}) $display("FAIL b2b_resp got %0h/%h want 1/77", a_p0_resp, a_p0_data); else n_pass++;
    cyc();
    n_chk++; if ({a_mem_req, a_mem_addr} !== {1'b1, 32'h600}) $display("FAIL b2b_reissue got %0h/%h want 1/600", a_mem_req, a_mem_addr); else n_pass++;
    mem_resp = 1'b1; mem_data = 32'h88;
    cyc(); mem_resp = 1'b0;
    n_chk++; if ({a_p0_resp, a_p0_data} !== {1'b1, 32'h88}) $display("FAIL b2b_resp2 got %0h/%h want 1/88", a_p0_resp, a_p0_data); else n_pass++;
  endtask

  task automatic test_spurious();
    cyc();
    mem_resp = 1'b1; mem_data = 32'h99;
    cyc(); mem_resp = 1'b0;
    n_chk++; if ({a_p0_resp, a_p1_resp} !== 2'b00) $display("FAIL spur_resp got %b want 00", {a_p0_resp, a_p1_resp}); else n_pass++;
    n_chk++; if ({a_busy, a_mem_req} !== 2'b00) $display("FAIL spur_state got %b want 00", {a_busy, a_mem_req}); else n_pass++;
    n_chk++; if ({a_p0_data, a_p1_data} !== {32'h88, 32'h66}) $display("FAIL spur_data_hold got %h/%h want 88/66", a_p0_data, a_p1_data); else n_pass++;
    cyc();
    n_chk++; if ({a_busy, a_mem_req} !== 2'b00) $display("FAIL spur_after got %b want 00", {a_busy, a_mem_req}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fixed_prio();
    test_round_robin();
    test_write();
    test_ignored();
    test_back_to_back();
    test_spurious();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached after %0d checks", n_chk);
    $fatal(1);
  end

endmodule
